// File: rtl/jtdsp16_ext_bridge.sv
// jtdsp16_ext_bridge: DSP16 external-ROM port to system memory bus bridge
// Latches the core address, runs the memory handshake with a one-cycle guard
// against stale ok and a watchdog, and holds the returned word for the core.
// ext_rq/ext_ok feed the clock-enable divider so it freezes while a read is pending.
// Optional one-entry read cache: define JTDSP16_EXTCACHE_EN.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cen                 master clock enable (debug qualifier only)
//   cendiv              divided enable, marks core instruction boundaries
//   core_rd, core_addr  core external read request and address
//   core_data           word returned to the core
//   ext_rq, ext_ok      access in progress / data valid, to the divider
//   rom_cs, rom_addr    memory request strobe and address
//   rom_data, rom_ok    memory data and data valid
//   err                 sticky watchdog-timeout flag
module jtdsp16_ext_bridge #(
   parameter int AW   = 16,
   parameter int DW   = 16,
   parameter int TOUT = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen,
   input  logic          cendiv,
   input  logic          core_rd,
   input  logic [AW-1:0] core_addr,
   output logic [DW-1:0] core_data,
   output logic          ext_rq,
   output logic          ext_ok,
   output logic          rom_cs,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data,
   input  logic          rom_ok,
   output logic          err
);
   localparam int CW = $clog2(TOUT);
   localparam logic [CW-1:0] CNT_MAX = CW'(TOUT - 1);
   typedef enum logic [1:0] {IDLE, GUARD, WAIT, DONE} state_t;
   state_t        st_q;
   logic [CW-1:0] cnt_q;
   logic [AW-1:0] rom_addr_q;
   logic [DW-1:0] core_data_q;
   logic          ext_rq_q, ext_ok_q, rom_cs_q, err_q;
   logic          dbg_unused;
   assign dbg_unused = cen;
`ifdef JTDSP16_EXTCACHE_EN
   logic [AW-1:0] tag_q;
   logic [DW-1:0] cword_q;
   logic          cval_q;
   logic          hit;
   assign hit = cval_q && (core_addr == tag_q);
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st_q        <= IDLE;
         cnt_q       <= '0;
         rom_addr_q  <= '0;
         core_data_q <= '0;
         ext_rq_q    <= 1'b0;
         ext_ok_q    <= 1'b0;
         rom_cs_q    <= 1'b0;
         err_q       <= 1'b0;
`ifdef JTDSP16_EXTCACHE_EN
         tag_q       <= '0;
         cword_q     <= '0;
         cval_q      <= 1'b0;
`endif
      end else begin
         case (st_q)
            IDLE: if (cendiv && core_rd) begin
               rom_addr_q <= core_addr;
               ext_rq_q   <= 1'b1;
               cnt_q      <= '0;
`ifdef JTDSP16_EXTCACHE_EN
               // a tag hit answers from the cache without touching memory
               ext_ok_q   <= hit;
               rom_cs_q   <= !hit;
               st_q       <= hit ? DONE : GUARD;
               if (hit) core_data_q <= cword_q;
`else
               ext_ok_q   <= 1'b0;
               rom_cs_q   <= 1'b1;
               st_q       <= GUARD;
`endif
            end
            // rom_ok here may belong to the arbiter's previous grant
            GUARD: st_q <= WAIT;
            WAIT: if (rom_ok) begin
               core_data_q <= rom_data;
               ext_ok_q    <= 1'b1;
               st_q        <= DONE;
`ifdef JTDSP16_EXTCACHE_EN
               tag_q       <= rom_addr_q;
               cword_q     <= rom_data;
               cval_q      <= 1'b1;
`endif
            end else if (cnt_q == CNT_MAX) begin
               core_data_q <= '1;
               err_q       <= 1'b1;
               ext_ok_q    <= 1'b1;
               st_q        <= DONE;
            end else cnt_q <= cnt_q + 1'b1;
            DONE: if (cendiv) begin
               if (!core_rd) begin
                  ext_rq_q <= 1'b0;
                  ext_ok_q <= 1'b0;
                  rom_cs_q <= 1'b0;
                  st_q     <= IDLE;
               end else if (core_addr != rom_addr_q) begin
                  // back-to-back access keeps the strobe up
                  rom_addr_q <= core_addr;
                  ext_ok_q   <= 1'b0;
                  rom_cs_q   <= 1'b1;
                  cnt_q      <= '0;
                  st_q       <= GUARD;
               end
            end
            default: st_q <= IDLE;
         endcase
      end
   assign core_data = core_data_q;
   assign ext_rq    = ext_rq_q;
   assign ext_ok    = ext_ok_q;
   assign rom_cs    = rom_cs_q;
   assign rom_addr  = rom_addr_q;
   assign err       = err_q;
endmodule

// File: tb/tb_jtdsp16_ext_bridge.sv
// tb_jtdsp16_ext_bridge: directed scoreboard bench for the external-ROM bridge
module tb_jtdsp16_ext_bridge;
   localparam int AW = 16, DW = 16, TOUT = 8;
   logic clk = 1'b0, rst_n = 1'b0, cen = 1'b1, cendiv = 1'b0, core_rd = 1'b0, rom_ok = 1'b0;
   logic [AW-1:0] core_addr = '0;
   logic [DW-1:0] rom_data = '0;
   logic [DW-1:0] core_data;
   logic [AW-1:0] rom_addr;
   logic ext_rq, ext_ok, rom_cs, err;
   int checks = 0, errors = 0;
   logic [DW-1:0] exp_q[$];
   always #5 clk = ~clk;
   jtdsp16_ext_bridge #(.AW(AW), .DW(DW), .TOUT(TOUT)) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .cendiv(cendiv), .core_rd(core_rd),
      .core_addr(core_addr), .core_data(core_data), .ext_rq(ext_rq), .ext_ok(ext_ok),
      .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok), .err(err)
   );
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic cd(input logic rd, input logic [AW-1:0] a);
      cendiv = 1'b1;
      core_rd = rd;
      core_addr = a;
      tick;
      cendiv = 1'b0;
   endtask
   task automatic pop_check(input string tag);
      check({tag, " sb depth"}, exp_q.size(), 1);
      if (exp_q.size() != 0) check({tag, " data"}, core_data, exp_q.pop_front());
   endtask
   task automatic wait_ok(input string tag, input logic [AW-1:0] a, input int lat);
      int n = 0;
      logic stable = 1'b1;
      while (!ext_ok && n < 40) begin
         tick;
         n++;
         if (rom_cs !== 1'b1 || rom_addr !== a) stable = 1'b0;
      end
      check({tag, " latency"}, n, lat);
      check({tag, " cs/addr stable"}, stable, 1);
      pop_check(tag);
   endtask
   task automatic rel(input string tag);
      cd(1'b0, '0);
      check({tag, " rel rq"}, ext_rq, 0);
      check({tag, " rel ok"}, ext_ok, 0);
      check({tag, " rel cs"}, rom_cs, 0);
   endtask
   initial begin
      tick;
      tick;
      check("rst rq", ext_rq, 0);
      check("rst ok", ext_ok, 0);
      check("rst cs", rom_cs, 0);
      check("rst err", err, 0);
      check("rst addr", rom_addr, 0);
      check("rst data", core_data, 0);
      @(negedge clk) rst_n = 1'b1;
      tick;
      // normal read, rom_ok arrives late in WAIT
      rom_data = 16'hBEEF;
      exp_q.push_back(16'hBEEF);
      cd(1'b1, 16'h1234);
      check("rd1 cs", rom_cs, 1);
      check("rd1 addr", rom_addr, 16'h1234);
      check("rd1 rq", ext_rq, 1);
      check("rd1 ok low", ext_ok, 0);
      repeat (4) tick;
      check("rd1 ok still low", ext_ok, 0);
      rom_ok = 1'b1;
      wait_ok("rd1", 16'h1234, 1);
      rom_ok = 1'b0;
      tick;
      check("rd1 hold ok", ext_ok, 1);
      check("rd1 hold rq", ext_rq, 1);
      rel("rd1");
      // stale ok already high before the request
      rom_ok = 1'b1;
      rom_data = 16'hDEAD;
      exp_q.push_back(16'hCAFE);
      cd(1'b1, 16'h0055);
      tick;
      check("stale guard ok", ext_ok, 0);
      rom_data = 16'hCAFE;
      wait_ok("stale", 16'h0055, 1);
      rom_ok = 1'b0;
      rel("stale");
      // watchdog timeout
      exp_q.push_back(16'hFFFF);
      cd(1'b1, 16'h0077);
      check("tout err early", err, 0);
      wait_ok("tout", 16'h0077, TOUT + 1);
      check("tout err", err, 1);
      rel("tout");
      check("tout err sticky", err, 1);
      rom_data = 16'h1111;
      exp_q.push_back(16'h1111);
      cd(1'b1, 16'h1000);
      rom_ok = 1'b1;
      wait_ok("post tout", 16'h1000, 2);
      rom_ok = 1'b0;
      check("post tout err", err, 1);
      rel("post tout");
      // back-to-back accesses
      rom_data = 16'hA001;
      exp_q.push_back(16'hA001);
      cd(1'b1, 16'h0001);
      rom_ok = 1'b1;
      wait_ok("b2b1", 16'h0001, 2);
      rom_ok = 1'b0;
      rom_data = 16'hA002;
      exp_q.push_back(16'hA002);
      cd(1'b1, 16'h0002);
      check("b2b ok drop", ext_ok, 0);
      check("b2b cs", rom_cs, 1);
      check("b2b rq", ext_rq, 1);
      check("b2b addr", rom_addr, 16'h0002);
      rom_ok = 1'b1;
      wait_ok("b2b2", 16'h0002, 2);
      rom_ok = 1'b0;
      cd(1'b1, 16'h0002);
      check("same addr ok", ext_ok, 1);
      check("same addr cs", rom_cs, 1);
      check("same addr data", core_data, 16'hA002);
      rel("b2b");
      // asynchronous reset in WAIT
      cd(1'b1, 16'h3333);
      tick;
      tick;
      #3 rst_n = 1'b0;
      #1;
      check("arst rq", ext_rq, 0);
      check("arst ok", ext_ok, 0);
      check("arst cs", rom_cs, 0);
      check("arst err", err, 0);
      check("arst addr", rom_addr, 0);
      check("arst data", core_data, 0);
      core_rd = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      rom_ok = 1'b1;
      rom_data = 16'h5555;
      repeat (3) tick;
      check("idle pend ok", ext_ok, 0);
      check("idle pend cs", rom_cs, 0);
      check("idle pend rq", ext_rq, 0);
      check("idle pend data", core_data, 0);
      rom_ok = 1'b0;
`ifdef JTDSP16_EXTCACHE_EN
      rom_data = 16'h1010;
      exp_q.push_back(16'h1010);
      cd(1'b1, 16'h0010);
      check("c miss cs", rom_cs, 1);
      rom_ok = 1'b1;
      wait_ok("c miss", 16'h0010, 2);
      rom_ok = 1'b0;
      rel("c miss");
      rom_data = 16'h0000;
      exp_q.push_back(16'h1010);
      cd(1'b1, 16'h0010);
      check("c hit cs", rom_cs, 0);
      check("c hit ok", ext_ok, 1);
      check("c hit rq", ext_rq, 1);
      pop_check("c hit");
      rel("c hit");
      exp_q.push_back(16'hFFFF);
      cd(1'b1, 16'h0020);
      wait_ok("c tout", 16'h0020, TOUT + 1);
      rel("c tout");
      rom_data = 16'h2020;
      exp_q.push_back(16'h2020);
      cd(1'b1, 16'h0020);
      check("c refetch cs", rom_cs, 1);
      check("c refetch ok", ext_ok, 0);
      rom_ok = 1'b1;
      wait_ok("c refetch", 16'h0020, 2);
      rom_ok = 1'b0;
      rel("c refetch");
`endif
      check("sb empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/jtdsp16_ext_bridge.md
Name: jtdsp16_ext_bridge

Overview:
- Sits between the DSP16 core's external-ROM port and the system memory bus (SDRAM/BRAM arbiter).
- Directly upstream of the internal clock-enable divider: produces the ext_rq/ext_ok pair that freezes the divided enable while an external read is outstanding.
- Latches the core address, runs the memory handshake with stale-ok filtering and a watchdog, and holds the returned word for the core.

Parameters:
- AW, 16, external address width.
- DW, 16, data width.
- TOUT, 255, watchdog limit in clk cycles spent in WAIT. Minimum 4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cen  in  1  master clock enable. Unused except as a debug qualifier.
- cendiv  in  1  divided enable from the divider. Marks core instruction boundaries.
- core_rd  in  1  core requests an external read for the current instruction.
- core_addr  in  AW  external address from the core.
- core_data  out  DW  word returned to the core.
- ext_rq  out  1  external access in progress; feeds the divider.
- ext_ok  out  1  data valid; releases the divider.
- rom_cs  out  1  memory request strobe.
- rom_addr  out  AW  memory address.
- rom_data  in  DW  memory data.
- rom_ok  in  1  memory data valid.
- err  out  1  sticky watchdog-timeout flag.

Behaviour:
- Reset (rst_n low, asynchronous) clears:
  - State to IDLE.
  - ext_rq, ext_ok, rom_cs and err to 0.
  - rom_addr and core_data to 0.
  - Watchdog counter to 0.
- Reset mid-transaction aborts immediately. No data is latched.
- IDLE:
  - When cendiv && core_rd: latch rom_addr<=core_addr, set rom_cs=1, ext_rq=1, ext_ok=0, clear the watchdog counter, go to GUARD.
  - cendiv without core_rd: no action.
- GUARD (exactly 1 cycle):
  - rom_ok is ignored here. This rejects a stale ok left over from the arbiter's previous grant.
  - Go to WAIT.
- WAIT:
  - On rom_ok=1: core_data<=rom_data, ext_ok<=1 (visible the next cycle), go to DONE.
  - Otherwise increment the counter.
  - When the counter reaches TOUT-1 with no rom_ok: core_data<=all ones, err<=1, ext_ok<=1, go to DONE.
  - If rom_ok and the timeout occur in the same cycle, rom_ok wins and err is unchanged.
- DONE:
  - rom_cs stays high; ext_rq=1 and ext_ok=1 hold.
  - On the next cendiv:
    - If core_rd and core_addr != rom_addr: latch the new address, ext_ok=0, go to GUARD (back-to-back access, rom_cs stays high).
    - If core_rd and the address is unchanged: stay in DONE.
    - If !core_rd: ext_rq=0, ext_ok=0, rom_cs=0, go to IDLE.
- Output and handshake rules:
  - rom_addr is stable for the whole time rom_cs is high within one transaction.
  - ext_rq never deasserts while ext_ok is 0. This guarantees the divider never advances on missing data.
  - Latency: with rom_ok held high, ext_ok rises 3 clk after the cendiv cycle (latch, GUARD, WAIT capture).
  - All outputs are registered. No combinational path from rom_ok to ext_ok.
- err clears only on reset.

Optional Feature:
- Macro: JTDSP16_EXTCACHE_EN.
- With the macro defined:
  - A one-entry tag/data register holds the last successfully read address/word. Timeout results are never cached.
  - In IDLE, if cendiv && core_rd && the cache is valid && core_addr matches the tag: core_data loads the cached word, ext_rq=1 and ext_ok=1 the next cycle, go to DONE without asserting rom_cs.
  - The cache valid bit clears on reset.
- Without the macro: every access goes through GUARD/WAIT. No tag logic is synthesised.

Test Plan:
- Normal read: core_rd=1, core_addr=16'h1234 at cendiv, rom_ok high 5 cycles later with rom_data=16'hBEEF -> rom_addr=16'h1234, rom_cs high throughout; ext_ok rises the cycle after rom_ok; core_data=16'hBEEF; the next cendiv with core_rd=0 drops ext_rq, ext_ok and rom_cs.
- Stale ok: rom_ok already high when the request starts and stays high -> ignored in GUARD; data captured in WAIT; ext_ok 3 cycles after cendiv.
- Timeout: TOUT=8, rom_ok never asserts -> ext_ok rises after WAIT has spent 8 cycles; core_data=16'hFFFF; err=1 and stays 1 through later good reads.
- Back-to-back: in DONE, cendiv with core_rd=1 and address 16'h0002 after 16'h0001 -> ext_ok drops, rom_cs stays high, rom_addr=16'h0002, GUARD/WAIT repeat.
- Async reset: assert rst_n=0 in WAIT, off-edge -> all outputs 0 immediately; after release, IDLE ignores a pending rom_ok.
- JTDSP16_EXTCACHE_EN: read 16'h0010 twice -> first access asserts rom_cs; second sees no rom_cs, ext_ok 1 cycle after cendiv, same data. A timed-out address is re-fetched, not served from the cache.
